// File: rtl/instr_fetch_master.sv
// Instruction fetch bus master: one word read per aligned fetch request, with
// branch-flush discard, misalignment fault and optional big-endian byte swap.
module instr_fetch_master #(
    parameter bit BYTE_SWAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] address,
    output logic        read,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_address;
    logic [31:0] r_instr;
    logic [31:0] r_fetch_count;
    logic        r_discard;
    logic        w_read;
    logic        w_stall;
    logic        w_instr_valid;
    logic        w_fault;
    logic        w_start;
    logic        w_capture;

    function automatic logic [31:0] f_order(input logic [31:0] d);
        if (BYTE_SWAP)
            return {d[7:0], d[15:8], d[23:16], d[31:24]};
        else
            return d;
    endfunction

    assign w_start   = (r_state == IDLE) && fetch_req && (pc[1:0] == 2'b00);
    assign w_capture = (r_state == READ) && !waitrequest && !r_discard && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_read        = 1'b0;
        w_stall       = 1'b0;
        w_instr_valid = 1'b0;
        w_fault       = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_req) begin
                    if (pc[1:0] == 2'b00) begin
                        w_stall = 1'b1;
                        w_next  = READ;
                    end else begin
                        w_next  = FAULT;
                    end
                end
            end
            READ: begin
                w_read  = 1'b1;
                w_stall = 1'b1;
                // The read must complete on the bus even when its result is unwanted.
                if (!waitrequest)
                    w_next = (r_discard || flush) ? IDLE : DONE;
            end
            DONE: begin
                w_instr_valid = 1'b1;
                w_next        = IDLE;
            end
            FAULT: begin
                w_fault = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address     <= 32'd0;
            r_discard     <= 1'b0;
            r_instr       <= 32'd0;
            r_fetch_count <= 32'd0;
        end else begin
            if (w_start) begin
                r_address <= pc;
                r_discard <= flush;
            end else if ((r_state == READ) && flush) begin
                r_discard <= 1'b1;
            end
            if (w_capture) begin
                r_instr       <= f_order(readdata);
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Reset gates the combinational stall so it reads 0 while reset is held.
    assign stall       = w_stall && !reset;
    assign read        = w_read;
    assign byteenable  = w_read ? 4'b1111 : 4'b0000;
    assign address     = r_address;
    assign instr       = r_instr;
    assign instr_valid = w_instr_valid;
    assign fault       = w_fault;
    assign fetch_count = r_fetch_count;

endmodule

// File: doc/instr_fetch_master.md
INSTR_FETCH_MASTER -- requirements
Module: instr_fetch_master

Interface
REQ-001 Parameter: BYTE_SWAP, 1, when 1 instr is readdata byte-reversed (big-endian MIPS word on little-endian bus); when 0 instr = readdata.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-004 fetch_req  in  1  CPU requests instruction fetch at pc (held high while in FETCH_INSTR).
REQ-005 pc  in  32  fetch byte address from PC register.
REQ-006 flush  in  1  discard result of any fetch in flight (branch redirect).
REQ-007 address  out  32  bus word address.
REQ-008 read  out  1  bus read strobe.
REQ-009 byteenable  out  4  bus byte lanes.
REQ-010 waitrequest  in  1  bus not ready; read/address must be held while high.
REQ-011 readdata  in  32  bus read data, valid in the cycle read=1 and waitrequest=0.
REQ-012 instr  out  32  last captured instruction.
REQ-013 instr_valid  out  1  one-cycle pulse: instr newly updated.
REQ-014 stall  out  1  tells PC register to hold.
REQ-015 fault  out  1  one-cycle pulse: misaligned fetch rejected.
REQ-016 fetch_count  out  32  count of delivered (non-discarded) instructions.

Function
REQ-017 FSM states SHALL be IDLE, READ, DONE, FAULT.
REQ-018 IDLE: read=0; on fetch_req=1 and pc[1:0]=00, latch address<=pc, discard<=flush, go READ.
REQ-019 IDLE: on fetch_req=1 and pc[1:0]!=00, go FAULT; no bus access issued; address unchanged.
REQ-020 READ: read=1, byteenable=4'b1111, address stable for entire state.
REQ-021 READ with waitrequest=1: stay READ; no output other than stall changes.
REQ-022 READ with waitrequest=0 and discard=0 and flush=0: instr<=readdata (swapped per BYTE_SWAP), fetch_count<=fetch_count+1, go DONE.
REQ-023 READ with waitrequest=0 and (discard=1 or flush=1): instr and fetch_count unchanged, go IDLE.
REQ-024 flush=1 in READ while waitrequest=1: set discard<=1; read SHALL NOT be dropped (bus protocol).
REQ-025 DONE: instr_valid=1 for exactly this cycle, read=0; go IDLE unconditionally; flush in DONE has no effect on instr/instr_valid.
REQ-026 FAULT: fault=1 for exactly this cycle, read=0, stall=0; go IDLE.
REQ-027 stall SHALL be 1 in READ, and combinationally 1 in IDLE when fetch_req=1 with aligned pc; 0 otherwise.
REQ-028 Back-to-back fetches SHALL take minimum 3 cycles (IDLE->READ->DONE); fetch_req in DONE is ignored until IDLE.
REQ-029 BYTE_SWAP=1: instr = {readdata[7:0],readdata[15:8],readdata[23:16],readdata[31:24]}.
REQ-030 fetch_count SHALL wrap 32'hFFFFFFFF -> 0 without flag.
REQ-031 byteenable SHALL be 4'b0000 whenever read=0.

Reset
REQ-032 On reset=1: state=IDLE, address=0, read=0, byteenable=0, instr=0, instr_valid=0, stall=0, fault=0, fetch_count=0, discard=0.
REQ-033 Reset asserted mid-READ SHALL deassert read immediately (asynchronously); no instr capture, no count increment.
REQ-034 After reset release, first fetch_req is honoured on the first posedge with reset=0.

Verification
REQ-035 pc=0x0000_0010, fetch_req=1, waitrequest=0, readdata=0x1234_5678, BYTE_SWAP=1 -> read=1 one cycle at address 0x10; next cycle instr=0x7856_3412, instr_valid=1 one cycle, fetch_count=1.
REQ-036 Same with waitrequest=1 for 3 cycles -> read and address=0x10 held 4 cycles, stall=1 throughout, instr_valid one cycle after waitrequest falls.
REQ-037 pc=0x0000_0013, fetch_req=1 -> fault=1 one cycle, read never asserted, instr and fetch_count unchanged.
REQ-038 flush=1 during READ with waitrequest=1 -> read held until waitrequest=0, then IDLE, no instr_valid, fetch_count unchanged.
REQ-039 reset asserted between clock edges during READ -> read=0 before next edge, all outputs at reset values.
REQ-040 fetch_count preloaded near wrap (drive 2^32 fetches or force 0xFFFF_FFFF) then one fetch -> fetch_count=0.
